// File: rtl/crack_controller_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : crack_controller_if
// Brief    : Host, guess-generator and MD5-pipeline signals of the cracker
//            run controller. master = controller, slave = host/generator side.
// Revision : 1.0
// ============================================================================
interface crack_controller_if #(
    parameter int CNT_WIDTH = 48
);
    logic                 start;
    logic                 abort;
    logic [2:0]           cfg_charset;
    logic [3:0]           cfg_guesslen;
    logic                 tgt_wr;
    logic [1:0]           tgt_sel;
    logic [31:0]          tgt_data;
    logic                 gen_reset;
    logic [2:0]           gen_charset;
    logic [3:0]           gen_guesslen;
    logic                 gen_done;
    logic [31:0]          hashA;
    logic [31:0]          hashB;
    logic [31:0]          hashC;
    logic [31:0]          hashD;
    logic                 busy;
    logic                 found;
    logic                 exhausted;
    logic [CNT_WIDTH-1:0] hit_index;
    logic [7:0]           hit_count;
    logic [CNT_WIDTH-1:0] guesses_done;

    modport master (
        input  start, abort, cfg_charset, cfg_guesslen, tgt_wr, tgt_sel, tgt_data,
               gen_done, hashA, hashB, hashC, hashD,
        output gen_reset, gen_charset, gen_guesslen, busy, found, exhausted,
               hit_index, hit_count, guesses_done
    );

    modport slave (
        output start, abort, cfg_charset, cfg_guesslen, tgt_wr, tgt_sel, tgt_data,
               gen_done, hashA, hashB, hashC, hashD,
        input  gen_reset, gen_charset, gen_guesslen, busy, found, exhausted,
               hit_index, hit_count, guesses_done
    );
endinterface
`default_nettype wire

// File: rtl/crack_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : crack_controller
// Brief    : Run sequencer for the MD5 brute-force cracker: target storage,
//            generator reset, in-flight tracking and digest compare.
//            Option macro CRACK_CTL_MULTIHIT_EN: keep running after a match.
// Revision : 1.0
// ============================================================================
module crack_controller #(
    parameter int PIPE_LATENCY = 64,
    parameter int CNT_WIDTH    = 48
) (
    input wire                 clk,
    input wire                 reset,
    crack_controller_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRIME     = 3'd1,
        S_RUN       = 3'd2,
        S_DRAIN     = 3'd3,
        S_FOUND     = 3'd4,
        S_EXHAUSTED = 3'd5
    } state_t;

    localparam logic [PIPE_LATENCY-1:0] c_valid_lsb = 1;
    localparam logic [CNT_WIDTH-1:0]    c_cnt_one   = 1;

    state_t                  state_q, state_d;
    logic [PIPE_LATENCY-1:0] valid_q, valid_d;
    logic [3:0][31:0]        tgt_q, tgt_d;
    logic [2:0]              charset_q, charset_d;
    logic [3:0]              guesslen_q, guesslen_d;
    logic                    found_q, found_d;
    logic                    exhausted_q, exhausted_d;
    logic [CNT_WIDTH-1:0]    hit_index_q, hit_index_d;
    logic [7:0]              hit_count_q, hit_count_d;
    logic [CNT_WIDTH-1:0]    guesses_done_q, guesses_done_d;
    logic                    gen_reset_q, gen_reset_d;
    logic                    busy_q, busy_d;

    logic run_active;
    logic cmp_valid;
    logic hit;

    assign run_active = (state_q == S_PRIME) || (state_q == S_RUN) || (state_q == S_DRAIN);
    // The MSB of the valid register marks the guess whose digest is on hashA..D now.
    assign cmp_valid  = valid_q[PIPE_LATENCY-1] && ((state_q == S_RUN) || (state_q == S_DRAIN));
    assign hit        = cmp_valid &&
                        ({bus.hashA, bus.hashB, bus.hashC, bus.hashD} ==
                         {tgt_q[0], tgt_q[1], tgt_q[2], tgt_q[3]});

    always_comb begin
        state_d        = state_q;
        valid_d        = valid_q << 1;
        tgt_d          = tgt_q;
        charset_d      = charset_q;
        guesslen_d     = guesslen_q;
        found_d        = found_q;
        exhausted_d    = exhausted_q;
        hit_index_d    = hit_index_q;
        hit_count_d    = hit_count_q;
        guesses_done_d = guesses_done_q;

        if (bus.tgt_wr && !run_active) begin
            tgt_d[bus.tgt_sel] = bus.tgt_data;
        end

        if (bus.abort && run_active) begin
            state_d = S_IDLE;
            valid_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_FOUND, S_EXHAUSTED: begin
                    if (bus.start && !bus.abort) begin
                        state_d        = S_PRIME;
                        valid_d        = '0;
                        charset_d      = bus.cfg_charset;
                        guesslen_d     = bus.cfg_guesslen;
                        found_d        = 1'b0;
                        exhausted_d    = 1'b0;
                        hit_index_d    = '0;
                        hit_count_d    = '0;
                        guesses_done_d = '0;
                    end
                end
                S_PRIME: state_d = S_RUN;
                S_RUN: begin
                    valid_d = (valid_q << 1) | c_valid_lsb;
                    if (bus.gen_done) begin
                        state_d = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (valid_d == '0) begin
                        state_d     = S_EXHAUSTED;
                        exhausted_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            if (cmp_valid) begin
                if (guesses_done_q != '1) begin
                    guesses_done_d = guesses_done_q + c_cnt_one;
                end
                if (hit) begin
                    found_d = 1'b1;
                    if (!found_q) begin
                        hit_index_d = guesses_done_q;
                    end
                    if (hit_count_q != 8'hFF) begin
                        hit_count_d = hit_count_q + 8'd1;
                    end
`ifndef CRACK_CTL_MULTIHIT_EN
                    state_d     = S_FOUND;
                    exhausted_d = 1'b0;
`endif
                end
            end
        end

        gen_reset_d = !((state_d == S_RUN) || (state_d == S_DRAIN));
        busy_d      = (state_d == S_PRIME) || (state_d == S_RUN) || (state_d == S_DRAIN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            valid_q        <= '0;
            tgt_q          <= '0;
            charset_q      <= '0;
            guesslen_q     <= '0;
            found_q        <= 1'b0;
            exhausted_q    <= 1'b0;
            hit_index_q    <= '0;
            hit_count_q    <= '0;
            guesses_done_q <= '0;
            gen_reset_q    <= 1'b1;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            valid_q        <= valid_d;
            tgt_q          <= tgt_d;
            charset_q      <= charset_d;
            guesslen_q     <= guesslen_d;
            found_q        <= found_d;
            exhausted_q    <= exhausted_d;
            hit_index_q    <= hit_index_d;
            hit_count_q    <= hit_count_d;
            guesses_done_q <= guesses_done_d;
            gen_reset_q    <= gen_reset_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.gen_reset    = gen_reset_q;
    assign bus.gen_charset  = charset_q;
    assign bus.gen_guesslen = guesslen_q;
    assign bus.busy         = busy_q;
    assign bus.found        = found_q;
    assign bus.exhausted    = exhausted_q;
    assign bus.hit_index    = hit_index_q;
    assign bus.hit_count    = hit_count_q;
    assign bus.guesses_done = guesses_done_q;
endmodule
`default_nettype wire

// File: doc/crack_controller.md
# crack_controller

Run-control sequencer for the MD5 brute-force cracker. It holds the 128-bit target digest, latches the charset and guess length for a run, and drives the guess generator's reset. It tracks which guesses are inside the fixed-latency MD5 pipeline, compares valid digests against the target, and reports found/exhausted status plus the index of the matching guess. It sits between the host/command logic and the guess generator + MD5 pipeline pair.

## Interface
- PIPE_LATENCY, 64: cycles from a guess leaving the generator to its digest on hashA..hashD (at least 1).
- CNT_WIDTH, 48: width of guess/compare counters.

- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle run request
- abort  in  1  one-cycle stop request
- cfg_charset  in  3  charset for next run
- cfg_guesslen  in  4  guess length for next run
- tgt_wr  in  1  target word write strobe
- tgt_sel  in  2  0=A, 1=B, 2=C, 3=D
- tgt_data  in  32  target word
- gen_reset  out  1  guess generator reset
- gen_charset  out  3  latched charset
- gen_guesslen  out  4  latched guess length
- gen_done  in  1  generator is presenting its last guess this cycle
- hashA, hashB, hashC, hashD  in  32 each  pipeline digest
- busy  out  1  high in PRIME, RUN and DRAIN
- found  out  1  match latched
- exhausted  out  1  keyspace finished with no match
- hit_index  out  CNT_WIDTH  0-based ordinal of first matching guess
- hit_count  out  8  number of matches
- guesses_done  out  CNT_WIDTH  number of digests compared

## Operation
- States: IDLE, PRIME, RUN, DRAIN, FOUND, EXHAUSTED.
- Generator contract: while gen_reset=1 it loads its first guess. It presents guess n on the n-th cycle after gen_reset falls, with the first guess on the first cycle. gen_done is high on the cycle the last guess is presented.
- IDLE / FOUND / EXHAUSTED + start: latch cfg_charset and cfg_guesslen; clear found, exhausted, hit_index, hit_count, guesses_done and the valid shift register; go to PRIME.
- PRIME: gen_reset=1 for exactly one cycle, then go to RUN.
- RUN: each cycle shift a 1 into the PIPE_LATENCY-deep valid shift register. On gen_done, shift in that final 1 and go to DRAIN.
- DRAIN: shift in 0s. When the register is empty and no match occurs, go to EXHAUSTED.
- Compare: when the valid-register MSB is 1, compare hashA..D against the target. On every valid compare, guesses_done increments after the compare. On a match, hit_index takes the pre-increment guesses_done value.
- A match in RUN or DRAIN sets found, hit_count=1, and goes to FOUND. FOUND and EXHAUSTED are terminal until start.
- gen_reset is 1 in IDLE, PRIME, FOUND and EXHAUSTED; it is 0 in RUN and DRAIN.
- tgt_wr writes the target word only when busy=0. Writes while busy are ignored.
- abort in PRIME, RUN or DRAIN: go to IDLE and clear the valid register. Status outputs keep their values.
- Simultaneous events:
  - abort beats start.
  - A match beats gen_done and beats the drain-empty condition.
  - start is ignored while busy.
- guesses_done saturates at all-ones. hit_count saturates at 255.

## Timing
- Reset values: state IDLE, gen_reset=1, busy=0, found=0, exhausted=0, hit_index=0, hit_count=0, guesses_done=0, target=0, gen_charset=0, gen_guesslen=0.
- start at cycle t:
  - PRIME at t+1; RUN at t+2.
  - The first guess is presented at t+2.
  - Its digest is compared at t+2+PIPE_LATENCY.
- All outputs are registered. found and hit_index are visible the cycle after the matching compare.
- exhausted is asserted PIPE_LATENCY+1 cycles after the gen_done cycle.
- reset mid-run forces all reset values on the next edge.

## Configuration
- CRACK_CTL_MULTIHIT_EN undefined:
  - First match ends the run (FOUND).
  - hit_count never exceeds 1.
- CRACK_CTL_MULTIHIT_EN defined:
  - A match sets found and stays in RUN/DRAIN.
  - hit_index keeps the first match only.
  - hit_count increments per match, saturating at 255.
  - The run ends in EXHAUSTED with found=1 when at least one match occurred.
  - exhausted is set at the end of every completed run.

## Test plan
- Reset → gen_reset=1, busy=0, found=0, exhausted=0, guesses_done=0 on the first post-reset cycle.
- PIPE_LATENCY=4, target words 0x98500190/0xb04fd23c/0x7d3f96d6/0x727fe128; model matches on guess 5 of 10 → found=1, hit_index=5, guesses_done=6, state FOUND, gen_reset=1.
- 10-guess run, no match → exhausted=1 exactly 5 cycles after gen_done; guesses_done=10; found=0.
- Match on the digest compared in the same cycle gen_done is asserted for a later guess → FOUND, not DRAIN or EXHAUSTED.
- abort 3 cycles into RUN, together with start → IDLE, start ignored. tgt_wr while busy leaves the target unchanged.
- With CRACK_CTL_MULTIHIT_EN, matches at indices 2 and 7 of 10 → hit_index=2, hit_count=2, found=1, exhausted=1.
